// File: rtl/ysyx_22050019_axi_pkg.sv
// Shared definitions for the instruction-SRAM AXI4-lite read responder:
// response codes, responder state encoding, default memory map and a
// lane-select helper for 32-bit fetches out of 64-bit SRAM words.
package ysyx_22050019_axi_pkg;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WAIT  = 2'd1,
        FETCH = 2'd2,
        RESP  = 2'd3
    } state_e;

    localparam logic [63:0] DEF_BASE_ADDR = 64'h0000_0000_8000_0000;
    localparam int          DEF_DEPTH     = 4096;

    // Seed loaded into the wait-state randomiser on reset.
    localparam logic [7:0]  LFSR_SEED     = 8'hA5;

    // Place the addressed 32-bit instruction in the low half of the beat.
    // The upper word is replicated so both halves carry it.
    function automatic logic [63:0] fetch_lane(input logic hi_sel, input logic [63:0] word);
        logic [63:0] lane;
        if (hi_sel) begin
            lane = {word[63:32], word[63:32]};
        end else begin
            lane = word;
        end
        return lane;
    endfunction

endpackage

// File: rtl/ysyx_22050019_lfsr8.sv
// 8-bit Fibonacci LFSR (taps 8,6,5,4) that free-runs every cycle.
// It exposes the two low bits that are used as a 0..3 cycle random
// wait-state extension in the instruction SRAM responder.
module ysyx_22050019_lfsr8
    import ysyx_22050019_axi_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    output logic [1:0] rnd_o
);

    logic [7:0] lfsr_q;
    logic [7:0] lfsr_d;
    logic       fb_s;

    // Feedback from taps 8,6,5,4 (bits 7,5,4,3), shifted in at the bottom.
    always_comb begin
        fb_s   = lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3];
        lfsr_d = {lfsr_q[6:0], fb_s};
    end

    // LFSR state register, reseeded on reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lfsr_q <= LFSR_SEED;
        end else begin
            lfsr_q <= lfsr_d;
        end
    end

    assign rnd_o = lfsr_q[1:0];

endmodule

// File: rtl/ysyx_22050019_isram_slv.sv
// AXI4-lite read-only responder (AR/R) in front of the instruction SRAM.
// One fetch is outstanding at a time. Misaligned fetches get SLVERR,
// fetches outside the SRAM window get DECERR without touching the SRAM,
// and in-range fetches wait WAIT_CYCLES before a one-cycle SRAM read.
// Build option: define ISRAM_RAND_DELAY_EN to add 0..3 random wait
// cycles per fetch from an 8-bit LFSR, which stresses IFU stall handling.
// Note that rst_n is active-high despite its name.
module ysyx_22050019_isram_slv
    import ysyx_22050019_axi_pkg::*;
#(
    parameter logic [63:0] BASE_ADDR   = DEF_BASE_ADDR,
    parameter int          DEPTH       = DEF_DEPTH,
    parameter int          AW          = 12,
    parameter int          WAIT_CYCLES = 0
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          s_axi_arvalid,
    output logic          s_axi_arready,
    input  logic [63:0]   s_axi_araddr,
    output logic          s_axi_rvalid,
    input  logic          s_axi_rready,
    output logic [63:0]   s_axi_rdata,
    output logic [1:0]    s_axi_rresp,
    output logic          mem_en,
    output logic [AW-1:0] mem_addr,
    input  logic [63:0]   mem_rdata
);

    // Exclusive upper bound of the SRAM window.
    localparam logic [63:0] END_ADDR = BASE_ADDR + (64'(DEPTH) << 3);
    // Wide enough for WAIT_CYCLES (<=15) plus up to 3 random cycles.
    localparam int          CW       = 5;

    state_e         state_q;
    state_e         state_d;
    logic [63:0]    addr_q;
    logic [63:0]    addr_d;
    logic [CW-1:0]  cnt_q;
    logic [CW-1:0]  cnt_d;
    logic           arready_q;
    logic           arready_d;
    logic           rvalid_q;
    logic           rvalid_d;
    logic [63:0]    rdata_q;
    logic [63:0]    rdata_d;
    logic [1:0]     rresp_q;
    logic [1:0]     rresp_d;
    logic [CW-1:0]  wait_load_s;
    logic           in_range_s;

`ifdef ISRAM_RAND_DELAY_EN
    logic [1:0]     rnd_s;

    ysyx_22050019_lfsr8 u_lfsr8 (
        .clk   (clk),
        .rst   (rst_n),
        .rnd_o (rnd_s)
    );

    assign wait_load_s = CW'(WAIT_CYCLES) + {3'b000, rnd_s};
`else
    assign wait_load_s = CW'(WAIT_CYCLES);
`endif

    // Unsigned window check on the incoming fetch address.
    assign in_range_s = (s_axi_araddr >= BASE_ADDR) && (s_axi_araddr < END_ADDR);

    // SRAM strobe is only raised on the last wait cycle; the word index
    // comes from the latched address relative to the window base.
    assign mem_en   = (state_q == WAIT) && (cnt_q == {CW{1'b0}});
    assign mem_addr = AW'((addr_q - BASE_ADDR) >> 3);

    assign s_axi_arready = arready_q;
    assign s_axi_rvalid  = rvalid_q;
    assign s_axi_rdata   = rdata_q;
    assign s_axi_rresp   = rresp_q;

    // Next-state and registered-output decode for the fetch sequencer.
    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        cnt_d     = cnt_q;
        arready_d = arready_q;
        rvalid_d  = rvalid_q;
        rdata_d   = rdata_q;
        rresp_d   = rresp_q;
        case (state_q)
            IDLE: begin
                if (s_axi_arvalid && arready_q) begin
                    addr_d    = s_axi_araddr;
                    cnt_d     = wait_load_s;
                    arready_d = 1'b0;
                    if (s_axi_araddr[1:0] != 2'b00) begin
                        rresp_d = RESP_SLVERR;
                        rdata_d = 64'd0;
                        state_d = RESP;
                    end else if (!in_range_s) begin
                        rresp_d = RESP_DECERR;
                        rdata_d = 64'd0;
                        state_d = RESP;
                    end else begin
                        state_d = WAIT;
                    end
                end else begin
                    state_d = IDLE;
                end
            end
            WAIT: begin
                if (cnt_q != {CW{1'b0}}) begin
                    cnt_d = cnt_q - 5'd1;
                end else begin
                    state_d = FETCH;
                end
            end
            FETCH: begin
                rdata_d  = fetch_lane(addr_q[2], mem_rdata);
                rresp_d  = RESP_OKAY;
                rvalid_d = 1'b1;
                state_d  = RESP;
            end
            RESP: begin
                // Error responses arrive here with rvalid still low and
                // raise it one cycle after the address handshake.
                if (!rvalid_q) begin
                    rvalid_d = 1'b1;
                end else if (s_axi_rready) begin
                    rvalid_d  = 1'b0;
                    arready_d = 1'b1;
                    state_d   = IDLE;
                end else begin
                    rvalid_d = 1'b1;
                end
            end
            default: begin
                state_d   = IDLE;
                arready_d = 1'b1;
                rvalid_d  = 1'b0;
            end
        endcase
    end

    // Sequencer state and registered AXI outputs; reset aborts any fetch.
    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            state_q   <= IDLE;
            addr_q    <= BASE_ADDR;
            cnt_q     <= {CW{1'b0}};
            arready_q <= 1'b1;
            rvalid_q  <= 1'b0;
            rdata_q   <= 64'd0;
            rresp_q   <= RESP_OKAY;
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            cnt_q     <= cnt_d;
            arready_q <= arready_d;
            rvalid_q  <= rvalid_d;
            rdata_q   <= rdata_d;
            rresp_q   <= rresp_d;
        end
    end

endmodule

// File: tb/tb_ysyx_22050019_isram_slv.sv
// Bench for the instruction SRAM responder. Two instances (WAIT_CYCLES 0
// and 3) share the same master stimulus; each has its own SRAM model and a
// transaction-level reference model that predicts every output per cycle.
module tb_ysyx_22050019_isram_slv;

    localparam logic [63:0] BASE  = 64'h0000_0000_8000_0000;
    localparam int          DEPTH = 4096;
    localparam int          AW    = 12;
    localparam logic [63:0] ENDA  = BASE + 64'(DEPTH) * 64'd8;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        arvalid = 1'b0;
    logic [63:0] araddr = 64'd0;
    logic        rready = 1'b0;

    logic [63:0] sram [DEPTH];

    int n_pass  = 0;
    int n_total = 0;

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    for (genvar g = 0; g < 2; g++) begin : g_dut
        localparam int NW = (g == 0) ? 0 : 3;
        localparam int GI = g;

        logic          arready;
        logic          rvalid;
        logic          mem_en;
        logic [63:0]   rdata;
        logic [63:0]   mem_rdata;
        logic [1:0]    rresp;
        logic [AW-1:0] mem_addr;

        ysyx_22050019_isram_slv #(
            .BASE_ADDR   (BASE),
            .DEPTH       (DEPTH),
            .AW          (AW),
            .WAIT_CYCLES (NW)
        ) u_dut (
            .clk           (clk),
            .rst_n         (rst),
            .s_axi_arvalid (arvalid),
            .s_axi_arready (arready),
            .s_axi_araddr  (araddr),
            .s_axi_rvalid  (rvalid),
            .s_axi_rready  (rready),
            .s_axi_rdata   (rdata),
            .s_axi_rresp   (rresp),
            .mem_en        (mem_en),
            .mem_addr      (mem_addr),
            .mem_rdata     (mem_rdata)
        );

        // synchronous-read SRAM
        always @(posedge clk) begin
            if (mem_en) mem_rdata <= sram[mem_addr];
        end

        // transaction-level reference model, stepped on every edge
        int            k = 0;
        bit            busy, rv_e, ar_e;
        int            mem_edge, rv_edge;
        logic [63:0]   exp_data;
        logic [1:0]    exp_resp;
        logic [AW-1:0] exp_maddr;
        logic [7:0]    lfsr;
        always @(posedge clk or posedge rst) begin
            int extra;
            logic [63:0] w;
            logic [63:0] idx;
            if (rst) begin
                busy = 1'b0; rv_e = 1'b0; ar_e = 1'b1;
                mem_edge = -1; rv_edge = -1; lfsr = 8'hA5;
            end else begin
                k++;
                extra = 0;
`ifdef ISRAM_RAND_DELAY_EN
                extra = int'(lfsr[1:0]);
`endif
                if (rv_e && rready) begin
                    rv_e = 1'b0; ar_e = 1'b1; busy = 1'b0;
                end else if (busy && !rv_e && k == rv_edge) begin
                    rv_e = 1'b1;
                end else if (!busy && ar_e && arvalid) begin
                    busy = 1'b1; ar_e = 1'b0;
                    if (araddr[1:0] != 2'b00) begin
                        exp_resp = 2'b10; exp_data = 64'd0; rv_edge = k + 1; mem_edge = -1;
                    end else if (araddr < BASE || araddr >= ENDA) begin
                        exp_resp = 2'b11; exp_data = 64'd0; rv_edge = k + 1; mem_edge = -1;
                    end else begin
                        idx = (araddr - BASE) / 64'd8;
                        w = sram[idx];
                        exp_data  = araddr[2] ? {w[63:32], w[63:32]} : w;
                        exp_resp  = 2'b00;
                        exp_maddr = idx[AW-1:0];
                        mem_edge  = k + NW + extra;
                        rv_edge   = k + 2 + NW + extra;
                    end
                end
                lfsr = {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
            end
        end

        // per-cycle compare plus observed latency/response capture
        logic        prev_ar = 1'b0;
        logic        prev_rv = 1'b0;
        int          obs_acc = 0;
        int          obs_lat = 0;
        logic [63:0] obs_data = 64'd0;
        logic [1:0]  obs_resp = 2'b00;
        always @(negedge clk) begin
            chk($sformatf("d%0d_arready", GI), 64'(arready), 64'(ar_e));
            chk($sformatf("d%0d_rvalid", GI), 64'(rvalid), 64'(rv_e));
            chk($sformatf("d%0d_mem_en", GI), 64'(mem_en), 64'(mem_edge == k));
            if (mem_edge == k) chk($sformatf("d%0d_mem_addr", GI), 64'(mem_addr), 64'(exp_maddr));
            if (rv_e) begin
                chk($sformatf("d%0d_rdata", GI), rdata, exp_data);
                chk($sformatf("d%0d_rresp", GI), 64'(rresp), 64'(exp_resp));
            end
            if (prev_ar && !arready) obs_acc = k;
            if (!prev_rv && rvalid) begin
                obs_lat  = k - obs_acc;
                obs_data = rdata;
                obs_resp = rresp;
                if (rresp != 2'b00) begin
                    chk($sformatf("d%0d_err_lat", GI), 64'(obs_lat), 64'd1);
                end else begin
`ifdef ISRAM_RAND_DELAY_EN
                    chk($sformatf("d%0d_lat_window", GI),
                        64'(obs_lat >= 2 + NW && obs_lat <= 5 + NW), 64'd1);
`else
                    chk($sformatf("d%0d_lat", GI), 64'(obs_lat), 64'(2 + NW));
`endif
                end
            end
            prev_ar = arready;
            prev_rv = rvalid;
        end
    end

    // one fetch on both instances; waits until both have completed it
    task automatic run_txn(input logic [63:0] a, input int hold_lo, input bit rnd_ready, input bit extra_av);
        bit done;
        done = 1'b0;
        @(negedge clk);
        arvalid = 1'b1; araddr = a; rready = 1'b0;
        @(negedge clk);
        if (extra_av) araddr = a ^ 64'h8;
        else arvalid = 1'b0;
        for (int c = 0; c < 200; c++) begin
            if (c < hold_lo) rready = 1'b0;
            else if (rnd_ready) rready = 1'($urandom_range(0, 1));
            else rready = 1'b1;
            @(negedge clk);
            arvalid = 1'b0;
            if (!g_dut[0].busy && !g_dut[1].busy) begin
                done = 1'b1;
                break;
            end
        end
        rready = 1'b0;
        chk("txn_timeout", 64'(done), 64'd1);
    endtask

    task automatic pin(input string nm, input logic [63:0] d0, input logic [63:0] d1,
                       input logic [1:0] r, input int l0, input int l1);
        chk({nm, "_d0_data"}, g_dut[0].obs_data, d0);
        chk({nm, "_d1_data"}, g_dut[1].obs_data, d1);
        chk({nm, "_d0_resp"}, 64'(g_dut[0].obs_resp), 64'(r));
        chk({nm, "_d1_resp"}, 64'(g_dut[1].obs_resp), 64'(r));
`ifndef ISRAM_RAND_DELAY_EN
        chk({nm, "_d0_lat"}, 64'(g_dut[0].obs_lat), 64'(l0));
        chk({nm, "_d1_lat"}, 64'(g_dut[1].obs_lat), 64'(l1));
`endif
    endtask

    initial begin
        int kind;
        int idx;
        logic [63:0] a;
        for (int i = 0; i < DEPTH; i++) sram[i] = {$urandom, $urandom};
        sram[0] = 64'h1111_1111_0000_0013;
        sram[1] = 64'hDEAD_BEEF_CAFE_F00D;
        sram[2] = 64'h0123_4567_89AB_CDEF;
        sram[DEPTH-1] = 64'h7777_6666_5555_4444;

        #1 rst = 1'b1;
        repeat (3) @(negedge clk);
        for (int g = 0; g < 2; g++) begin
            if (g == 0) begin
                chk("rst_d0_arready", 64'(g_dut[0].arready), 64'd1);
                chk("rst_d0_rvalid", 64'(g_dut[0].rvalid), 64'd0);
                chk("rst_d0_rdata", g_dut[0].rdata, 64'd0);
                chk("rst_d0_rresp", 64'(g_dut[0].rresp), 64'd0);
                chk("rst_d0_mem_en", 64'(g_dut[0].mem_en), 64'd0);
                chk("rst_d0_mem_addr", 64'(g_dut[0].mem_addr), 64'd0);
            end else begin
                chk("rst_d1_arready", 64'(g_dut[1].arready), 64'd1);
                chk("rst_d1_rvalid", 64'(g_dut[1].rvalid), 64'd0);
                chk("rst_d1_rdata", g_dut[1].rdata, 64'd0);
                chk("rst_d1_mem_addr", 64'(g_dut[1].mem_addr), 64'd0);
            end
        end
        rst = 1'b0;

        run_txn(BASE, 0, 1'b0, 1'b0);
        pin("w0_lo", 64'h1111_1111_0000_0013, 64'h1111_1111_0000_0013, 2'b00, 2, 5);
        chk("w0_lo32", 64'(g_dut[0].obs_data[31:0]), 64'h0000_0013);
        run_txn(BASE + 64'd4, 0, 1'b0, 1'b0);
        pin("w0_hi", 64'h1111_1111_1111_1111, 64'h1111_1111_1111_1111, 2'b00, 2, 5);
        run_txn(64'h0000_0000_7FFF_FFFC, 0, 1'b0, 1'b0);
        pin("below", 64'd0, 64'd0, 2'b11, 1, 1);
        run_txn(ENDA, 0, 1'b0, 1'b0);
        pin("top", 64'd0, 64'd0, 2'b11, 1, 1);
        run_txn(BASE + 64'd2, 0, 1'b0, 1'b1);
        pin("misal", 64'd0, 64'd0, 2'b10, 1, 1);
        run_txn(ENDA - 64'd4, 0, 1'b0, 1'b0);
        pin("last", 64'h7777_6666_7777_6666, 64'h7777_6666_7777_6666, 2'b00, 2, 5);
        run_txn(BASE + 64'd8, 5, 1'b0, 1'b0);
        pin("hold", 64'hDEAD_BEEF_CAFE_F00D, 64'hDEAD_BEEF_CAFE_F00D, 2'b00, 2, 5);

        // reset pulsed while the WAIT_CYCLES=3 instance is still waiting
        @(negedge clk);
        arvalid = 1'b1; araddr = BASE + 64'd16;
        @(negedge clk);
        arvalid = 1'b0;
        @(negedge clk);
        #1 rst = 1'b1;
        #1;
        chk("mid_rst_d0_rvalid", 64'(g_dut[0].rvalid), 64'd0);
        chk("mid_rst_d1_rvalid", 64'(g_dut[1].rvalid), 64'd0);
        chk("mid_rst_d0_arready", 64'(g_dut[0].arready), 64'd1);
        chk("mid_rst_d1_arready", 64'(g_dut[1].arready), 64'd1);
        chk("mid_rst_d1_mem_en", 64'(g_dut[1].mem_en), 64'd0);
        @(negedge clk);
        #1 rst = 1'b0;
        run_txn(BASE + 64'd16, 0, 1'b0, 1'b0);
        pin("after_rst", 64'h0123_4567_89AB_CDEF, 64'h0123_4567_89AB_CDEF, 2'b00, 2, 5);

        for (int t = 0; t < 150; t++) begin
            kind = $urandom_range(0, 9);
            idx  = $urandom_range(0, DEPTH - 1);
            case (kind)
                6:       a = BASE + 64'(idx) * 64'd8 + 64'($urandom_range(1, 7) & 32'h5 | 32'h1);
                7:       a = BASE - 64'($urandom_range(1, 64)) * 64'd4;
                8:       a = ENDA + 64'($urandom_range(0, 64)) * 64'd4;
                9:       a = {$urandom, $urandom} & ~64'h3;
                default: a = BASE + 64'(idx) * 64'd8 + 64'($urandom_range(0, 1)) * 64'd4;
            endcase
            run_txn(a, $urandom_range(0, 3), 1'b1, 1'($urandom_range(0, 1)));
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/ysyx_22050019_isram_slv.md
Name: ysyx_22050019_isram_slv

Overview:
AXI4-lite read-channel responder (AR/R only) serving instruction fetch. It is the slave end for the IFU's fetch master. It accepts one read address at a time, reads a 64-bit word from a synchronous-read SRAM macro, inserts configurable wait states, and returns data with a response code. It sits between the IFU's AXI read port and the instruction SRAM in the NPC simulation top.

Parameters:
BASE_ADDR, 64'h80000000, byte address of SRAM word 0
DEPTH, 4096, number of 64-bit SRAM words
AW, 12, SRAM word-address width, equal to clog2(DEPTH)
WAIT_CYCLES, 0, fixed extra cycles inserted before the SRAM read is issued (0..15)

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous, active-high reset (asserted = 1, despite the name)
s_axi_arvalid  in  1  read address valid
s_axi_arready  out  1  read address ready
s_axi_araddr  in  64  byte address of the fetch
s_axi_rvalid  out  1  read data valid
s_axi_rready  in  1  read data ready
s_axi_rdata  out  64  read data; the addressed 32-bit word is in [31:0]
s_axi_rresp  out  2  00 OKAY, 10 SLVERR, 11 DECERR
mem_en  out  1  SRAM read enable, one-cycle pulse
mem_addr  out  AW  SRAM word address
mem_rdata  in  64  SRAM data, valid in the cycle after mem_en

Behaviour:
- Reset (async, while rst_n=1): state IDLE, s_axi_arready=1, s_axi_rvalid=0, s_axi_rdata=0, s_axi_rresp=00, mem_en=0, mem_addr=0, wait counter=0.
- Only one transaction is outstanding. All outputs are registered except mem_en and mem_addr, which are decoded from state and the latched address.
- States:
  - IDLE: arready=1. On arvalid&&arready, latch araddr, load counter=WAIT_CYCLES, clear arready, then:
    - araddr[1:0]!=0: go to RESP with rresp=10 and rdata=0.
    - araddr outside [BASE_ADDR, BASE_ADDR+8*DEPTH): go to RESP with rresp=11 and rdata=0. No SRAM access.
    - otherwise go to WAIT.
  - WAIT: if counter!=0, decrement. If counter==0: mem_en=1, mem_addr=(addr-BASE_ADDR)[AW+2:3], go to FETCH.
  - FETCH: capture rdata = addr[2] ? {mem_rdata[63:32], mem_rdata[63:32]} : mem_rdata. Set rresp=00 and rvalid=1, go to RESP.
  - RESP: hold rvalid, rdata and rresp stable until rready. On rvalid&&rready: rvalid=0, arready=1, go to IDLE.
- Latency, with the AR handshake at edge T and WAIT_CYCLES=N: mem_en is high in cycle T+1+N and rvalid rises at edge T+2+N. An error response rises rvalid at edge T+1.
- After an R handshake, the next AR can be accepted no earlier than the following cycle. There is no combinational ready path.
- If arvalid is asserted while not in IDLE, it is ignored because arready=0. The master holds it.
- Address subtraction is 64-bit. The range check uses unsigned compares. The top bound is exclusive, so BASE_ADDR+8*DEPTH returns DECERR.
- Reset asserted mid-transaction aborts it immediately. rvalid drops with no response, and the block is back in IDLE with arready=1.

Optional Feature:
- Macro ISRAM_RAND_DELAY_EN.
- Defined: an 8-bit Fibonacci LFSR (taps 8,6,5,4; reset seed 8'hA5) advances every cycle. At each AR handshake, the counter loads WAIT_CYCLES + lfsr[1:0], giving 0..3 extra cycles. The purpose is to stress IFU stalls.
- Undefined: the counter loads WAIT_CYCLES only, and no LFSR logic exists.

Decomposition:
- Shared package ysyx_22050019_axi_pkg:
  - resp codes RESP_OKAY, RESP_SLVERR, RESP_DECERR
  - state encoding IDLE, WAIT, FETCH, RESP
  - default BASE_ADDR and DEPTH constants
- One sub-module, ysyx_22050019_lfsr8, instantiated only under ISRAM_RAND_DELAY_EN.

Test Plan:
- Reset, then araddr=0x80000000 with WAIT_CYCLES=0, SRAM word0=0x11111111_00000013 -> mem_en in cycle T+1, rvalid at T+2, rdata[31:0]=0x00000013, rresp=00.
- araddr=0x80000004, same word -> rdata[31:0]=0x11111111, rresp=00.
- araddr=0x7FFFFFFC, then araddr=0x80000000+8*DEPTH -> rresp=11, rdata=0, mem_en never asserted, rvalid at T+1.
- araddr=0x80000002 -> rresp=10, rdata=0.
- WAIT_CYCLES=3 with rready held low for 5 cycles -> rvalid at T+5 with rdata stable while rready is low. arready stays 0 until the cycle after the R handshake.
- rst_n pulsed during WAIT -> rvalid=0, arready=1 immediately, and the next fetch completes normally. With ISRAM_RAND_DELAY_EN, 100 fetches each complete with latency between 2 and 5 cycles.
